// File: rtl/mul_rs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mul_rs                                                           |
// | Purpose : M-extension reservation station, collapsing age-ordered queue   |
// |           with CDB snooping and oldest-ready issue.                       |
// | Option  : MUL_RS_CDB_BYPASS_EN enables same-cycle CDB wakeup-to-issue.    |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_rs #(
  parameter int DEPTH  = 4,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    dispatch_valid,
  output logic                    dispatch_ready,
  input  logic [2:0]              dispatch_op,
  input  logic [PREG_W-1:0]       dispatch_ps1,
  input  logic                    dispatch_ps1_rdy,
  input  logic [PREG_W-1:0]       dispatch_ps2,
  input  logic                    dispatch_ps2_rdy,
  input  logic [PREG_W-1:0]       dispatch_pd,
  input  logic [ROB_W-1:0]        dispatch_rob_id,
  input  logic                    cdb_valid,
  input  logic [PREG_W-1:0]       cdb_pd,
  output logic                    issue_valid,
  input  logic                    issue_ready,
  output logic [2:0]              issue_op,
  output logic [PREG_W-1:0]       issue_ps1,
  output logic [PREG_W-1:0]       issue_ps2,
  output logic [PREG_W-1:0]       issue_pd,
  output logic [ROB_W-1:0]        issue_rob_id,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int c_IDX_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [2:0]        op;
    logic [PREG_W-1:0] ps1;
    logic              r1;
    logic [PREG_W-1:0] ps2;
    logic              r2;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob_id;
  } entry_t;

  entry_t              r_slot     [DEPTH];
  entry_t              w_woken    [DEPTH];
  entry_t              w_slot_nxt [DEPTH];
  entry_t              w_new;
  entry_t              w_issue;
  logic [c_CNT_W-1:0]  r_occ;
  logic [c_CNT_W-1:0]  w_occ_base;
  logic [c_CNT_W-1:0]  w_occ_nxt;
  logic [DEPTH-1:0]    w_hit1;
  logic [DEPTH-1:0]    w_hit2;
  logic [DEPTH-1:0]    w_rdy;
  logic [c_IDX_W-1:0]  w_sel;
  logic                w_any;
  logic                w_fire;
  logic                w_disp;

  // Wakeup view of every slot, plus the per-slot issue eligibility.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woken[i] = r_slot[i];
      w_hit1[i]  = cdb_valid && (cdb_pd == r_slot[i].ps1);
      w_hit2[i]  = cdb_valid && (cdb_pd == r_slot[i].ps2);
      if (w_hit1[i] && (r_slot[i].ps1 != '0)) w_woken[i].r1 = 1'b1;
      if (w_hit2[i] && (r_slot[i].ps2 != '0)) w_woken[i].r2 = 1'b1;
`ifdef MUL_RS_CDB_BYPASS_EN
      w_rdy[i] = r_slot[i].valid && (r_slot[i].r1 || w_hit1[i])
                                 && (r_slot[i].r2 || w_hit2[i]);
`else
      w_rdy[i] = r_slot[i].valid && r_slot[i].r1 && r_slot[i].r2;
`endif
    end
  end

  // Lowest index wins: scanning downward leaves the oldest ready slot.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_rdy[i]) begin
        w_any = 1'b1;
        w_sel = c_IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_issue = '0;
    if (w_any) w_issue = r_slot[w_sel];
  end

  assign issue_valid    = w_any;
  assign issue_op       = w_issue.op;
  assign issue_ps1      = w_issue.ps1;
  assign issue_ps2      = w_issue.ps2;
  assign issue_pd       = w_issue.pd;
  assign issue_rob_id   = w_issue.rob_id;
  assign occupancy      = r_occ;
  assign dispatch_ready = (r_occ < c_DEPTH_CNT);

  assign w_fire     = w_any && issue_ready;
  assign w_disp     = dispatch_valid && dispatch_ready;
  assign w_occ_base = r_occ - {{(c_CNT_W-1){1'b0}}, w_fire};

  // A new entry may also catch the broadcast happening in its dispatch cycle.
  always_comb begin
    w_new        = '0;
    w_new.valid  = 1'b1;
    w_new.op     = dispatch_op;
    w_new.ps1    = dispatch_ps1;
    w_new.ps2    = dispatch_ps2;
    w_new.pd     = dispatch_pd;
    w_new.rob_id = dispatch_rob_id;
    w_new.r1     = dispatch_ps1_rdy || (dispatch_ps1 == '0)
                   || (cdb_valid && (cdb_pd == dispatch_ps1));
    w_new.r2     = dispatch_ps2_rdy || (dispatch_ps2 == '0)
                   || (cdb_valid && (cdb_pd == dispatch_ps2));
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      int src;
      src           = (i < DEPTH - 1) ? i + 1 : i;
      w_slot_nxt[i] = w_woken[i];
      if (w_fire && (i >= int'(w_sel))) begin
        if (i < DEPTH - 1) w_slot_nxt[i] = w_woken[src];
        else               w_slot_nxt[i] = '0;
      end
      if (w_disp && (c_CNT_W'(i) == w_occ_base)) w_slot_nxt[i] = w_new;
      if (flush) w_slot_nxt[i] = '0;
    end
    w_occ_nxt = w_occ_base + {{(c_CNT_W-1){1'b0}}, w_disp};
    if (flush) w_occ_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ <= '0;
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= '0;
    end else begin
      r_occ <= w_occ_nxt;
      for (int i = 0; i < DEPTH; i++) r_slot[i] <= w_slot_nxt[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_rs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mul_rs                                                        |
// | Purpose : Self-checking bench for mul_rs against a queue reference model. |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mul_rs;

  localparam int DEPTH  = 4;
  localparam int PREG_W = 6;
  localparam int ROB_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              dispatch_valid;
  logic              dispatch_ready;
  logic [2:0]        dispatch_op;
  logic [PREG_W-1:0] dispatch_ps1;
  logic              dispatch_ps1_rdy;
  logic [PREG_W-1:0] dispatch_ps2;
  logic              dispatch_ps2_rdy;
  logic [PREG_W-1:0] dispatch_pd;
  logic [ROB_W-1:0]  dispatch_rob_id;
  logic              cdb_valid;
  logic [PREG_W-1:0] cdb_pd;
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        issue_op;
  logic [PREG_W-1:0] issue_ps1;
  logic [PREG_W-1:0] issue_ps2;
  logic [PREG_W-1:0] issue_pd;
  logic [ROB_W-1:0]  issue_rob_id;
  logic [$clog2(DEPTH):0] occupancy;

  always #5 clk = ~clk;

  mul_rs #(.DEPTH(DEPTH), .PREG_W(PREG_W), .ROB_W(ROB_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_ps1(dispatch_ps1),
    .dispatch_ps1_rdy(dispatch_ps1_rdy), .dispatch_ps2(dispatch_ps2),
    .dispatch_ps2_rdy(dispatch_ps2_rdy), .dispatch_pd(dispatch_pd),
    .dispatch_rob_id(dispatch_rob_id), .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_ps1(issue_ps1), .issue_ps2(issue_ps2), .issue_pd(issue_pd),
    .issue_rob_id(issue_rob_id), .occupancy(occupancy)
  );

  typedef struct {
    int op; int ps1; bit r1; int ps2; bit r2; int pd; int rob;
  } ment_t;

  ment_t q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_ready(input ment_t e, input bit cv, input int cpd);
`ifdef MUL_RS_CDB_BYPASS_EN
    return (e.r1 || (cv && cpd == e.ps1)) && (e.r2 || (cv && cpd == e.ps2));
`else
    return e.r1 && e.r2;
`endif
  endfunction

  function automatic int m_select(input bit cv, input int cpd);
    for (int i = 0; i < q.size(); i++)
      if (m_ready(q[i], cv, cpd)) return i;
    return -1;
  endfunction

  // One clock: drive, check outputs against the model, clock, advance the model.
  task automatic cycle(input bit dv, input int op, input int ps1, input bit r1,
                       input int ps2, input bit r2, input int pd, input int rob,
                       input bit cv, input int cpd, input bit ir, input bit fl);
    int    sel;
    int    n0;
    ment_t e;
    logic [31:0] exp_f;
    dispatch_valid = dv; dispatch_op = op[2:0];
    dispatch_ps1 = ps1[PREG_W-1:0]; dispatch_ps1_rdy = r1;
    dispatch_ps2 = ps2[PREG_W-1:0]; dispatch_ps2_rdy = r2;
    dispatch_pd = pd[PREG_W-1:0]; dispatch_rob_id = rob[ROB_W-1:0];
    cdb_valid = cv; cdb_pd = cpd[PREG_W-1:0];
    issue_ready = ir; flush = fl;
    #1;
    sel = m_select(cv, cpd);
    n0  = q.size();
    exp_f = '0;
    if (sel >= 0)
      exp_f = {6'd0, q[sel].op[2:0], q[sel].ps1[5:0], q[sel].ps2[5:0],
               q[sel].pd[5:0], q[sel].rob[4:0]};
    chk("occupancy", 32'(occupancy), 32'(n0));
    chk("dispatch_ready", 32'(dispatch_ready), 32'(n0 < DEPTH));
    chk("issue_valid", 32'(issue_valid), 32'(sel >= 0));
    chk("issue_fields", {6'd0, issue_op, issue_ps1, issue_ps2, issue_pd, issue_rob_id}, exp_f);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (sel >= 0 && ir) q.delete(sel);
      foreach (q[i]) begin
        if (cv && cpd != 0 && cpd == q[i].ps1) q[i].r1 = 1'b1;
        if (cv && cpd != 0 && cpd == q[i].ps2) q[i].r2 = 1'b1;
      end
      if (dv && n0 < DEPTH) begin
        e.op = op; e.ps1 = ps1; e.ps2 = ps2; e.pd = pd; e.rob = rob;
        e.r1 = r1 || ps1 == 0 || (cv && cpd == ps1);
        e.r2 = r2 || ps2 == 0 || (cv && cpd == ps2);
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic idle(input bit ir, input bit cv, input int cpd);
    cycle(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, 0, cv, cpd, ir, 1'b0);
  endtask

  // Reset is asserted between edges; the station must clear without a clock.
  task automatic mid_reset();
    dispatch_valid = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; dispatch_op = '0;
    dispatch_ps1 = '0; dispatch_ps1_rdy = 1'b0; dispatch_ps2 = '0;
    dispatch_ps2_rdy = 1'b0; dispatch_pd = '0; dispatch_rob_id = '0;
    cdb_valid = 1'b0; cdb_pd = '0; issue_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_fields", {6'd0, issue_op, issue_ps1, issue_ps2, issue_pd, issue_rob_id}, 32'd0);
    chk("reset_occupancy", 32'(occupancy), 32'd0);

    // Ready-on-arrival MUL issues the next cycle.
    cycle(1'b1, 0, 3, 1'b1, 4, 1'b1, 10, 1, 1'b0, 0, 1'b1, 1'b0);
    idle(1'b1, 1'b0, 0);
    idle(1'b1, 1'b0, 0);

    // DIV waiting on tag 5, broadcast two cycles later.
    cycle(1'b1, 4, 5, 1'b0, 6, 1'b1, 11, 2, 1'b0, 0, 1'b1, 1'b0);
    idle(1'b1, 1'b0, 0);
    idle(1'b1, 1'b1, 5);
    idle(1'b1, 1'b0, 0);
    idle(1'b1, 1'b0, 0);

    // Fill to full, attempt a blocked dispatch, then release one.
    for (int i = 0; i < DEPTH; i++)
      cycle(1'b1, i, 1, 1'b1, 2, 1'b1, 12 + i, 3 + i, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 7, 1, 1'b1, 2, 1'b1, 30, 9, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 7, 1, 1'b1, 2, 1'b1, 31, 10, 1'b0, 0, 1'b1, 1'b0);
    idle(1'b0, 1'b0, 0);
    repeat (DEPTH + 1) idle(1'b1, 1'b0, 0);

    // Age order: older entry waits on tag 7, younger one issues first.
    cycle(1'b1, 5, 7, 1'b0, 1, 1'b1, 20, 4, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 6, 2, 1'b1, 3, 1'b1, 21, 5, 1'b0, 0, 1'b0, 1'b0);
    idle(1'b1, 1'b0, 0);
    idle(1'b1, 1'b1, 7);
    idle(1'b1, 1'b0, 0);
    idle(1'b1, 1'b0, 0);

    // Dispatch catches the same-cycle broadcast of its ps1.
    cycle(1'b1, 1, 9, 1'b0, 2, 1'b1, 22, 6, 1'b1, 9, 1'b1, 1'b0);
    idle(1'b1, 1'b0, 0);
    idle(1'b1, 1'b0, 0);

    // Flush with three held entries and a concurrent dispatch.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 2, 8, 1'b0, 1, 1'b1, 40 + i, 11 + i, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 3, 1, 1'b1, 2, 1'b1, 50, 20, 1'b0, 0, 1'b1, 1'b1);
    repeat (3) idle(1'b1, 1'b0, 0);

    // Reset while entries are held.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 0, 9, 1'b0, 1, 1'b1, 44 + i, 14 + i, 1'b0, 0, 1'b0, 1'b0);
    mid_reset();
    idle(1'b1, 1'b0, 0);

    // Randomized traffic over a small tag space so wakeups collide often.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        mid_reset();
      end else begin
        cycle($urandom_range(0, 9) < 6, $urandom_range(0, 7),
              $urandom_range(0, 7), $urandom_range(0, 3) == 0,
              $urandom_range(0, 7), $urandom_range(0, 3) == 0,
              $urandom_range(1, 63), $urandom_range(0, 31),
              $urandom_range(0, 1) == 1, $urandom_range(0, 7),
              $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
